// File: rtl/gnr_node_lut.sv
// Boolean-network node with NCOPY independent state lanes. Each lane evaluates
// a shared runtime-loadable K-input truth table, has its own update divider,
// and tracks how long its state has held still for attractor detection.
module gnr_node_lut #(
  parameter int unsigned NCOPY = 2,
  parameter int unsigned K     = 4,
  parameter int unsigned PW    = 4,
  parameter int unsigned SW    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reset_nos,
  input  logic [NCOPY-1:0]      init_state,
  input  logic                  cfg_we,
  input  logic [(2**K)-1:0]     cfg_lut,
  input  logic [NCOPY*PW-1:0]   cfg_period,
  input  logic [NCOPY-1:0]      start,
  input  logic [NCOPY*K-1:0]    in_bits,
  input  logic [SW-1:0]         stable_thr,
  output logic [NCOPY-1:0]      s,
  output logic [NCOPY-1:0]      changed,
  output logic [NCOPY-1:0]      stable
);

  localparam int unsigned LutW = 2 ** K;

  logic [LutW-1:0]     lut_q, lut_d;
  logic [NCOPY*PW-1:0] period_q, period_d;
  logic [NCOPY-1:0]    s_q, s_d;
  logic [NCOPY-1:0]    changed_q, changed_d;
  logic [PW-1:0]       phase_q [NCOPY];
  logic [PW-1:0]       phase_d [NCOPY];
  logic [SW-1:0]       scnt_q  [NCOPY];
  logic [SW-1:0]       scnt_d  [NCOPY];

  // Next-state: config load plus per-lane restart / evaluate / skip / hold.
  always_comb begin
    logic nxt;
    nxt       = 1'b0;
    lut_d     = lut_q;
    period_d  = period_q;
    s_d       = s_q;
    changed_d = '0;
    phase_d   = phase_q;
    scnt_d    = scnt_q;

    // An evaluation this cycle still sees lut_q, i.e. the old table.
    if (cfg_we) begin
      lut_d    = cfg_lut;
      period_d = cfg_period;
    end

    for (int c = 0; c < NCOPY; c++) begin
      if (reset_nos) begin
        s_d[c]     = init_state[c];
        phase_d[c] = '0;
        scnt_d[c]  = '0;
      end else if (start[c]) begin
        if (phase_q[c] == '0) begin
          nxt          = lut_q[in_bits[c*K +: K]];
          s_d[c]       = nxt;
          // Reload uses the registered period so a same-cycle cfg_we waits for the next reload.
          phase_d[c]   = period_q[c*PW +: PW];
          changed_d[c] = (nxt != s_q[c]);
          if (nxt != s_q[c]) begin
            scnt_d[c] = '0;
          end else if (scnt_q[c] != {SW{1'b1}}) begin
            scnt_d[c] = scnt_q[c] + SW'(1);
          end
        end else begin
          phase_d[c] = phase_q[c] - PW'(1);
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q     <= '0;
      period_q  <= '0;
      s_q       <= '0;
      changed_q <= '0;
      for (int c = 0; c < NCOPY; c++) begin
        phase_q[c] <= '0;
        scnt_q[c]  <= '0;
      end
    end else begin
      lut_q     <= lut_d;
      period_q  <= period_d;
      s_q       <= s_d;
      changed_q <= changed_d;
      phase_q   <= phase_d;
      scnt_q    <= scnt_d;
    end
  end

  // Stability flag follows the registered counter and the live threshold.
  always_comb begin
    stable = '0;
    for (int c = 0; c < NCOPY; c++) begin
      stable[c] = (stable_thr != '0) && (scnt_q[c] >= stable_thr);
    end
  end

  assign s       = s_q;
  assign changed = changed_q;

endmodule
